// File: rtl/riscv_dmem_resp_unit.sv
// Data-memory response path: formats load data, queues it in order, and tracks outstanding requests.
// Optional `RESP_BYPASS_EN lets a response skip the empty queue when its target port is ready.
module riscv_dmem_resp_unit #(
   parameter int RESP_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 dmem_req_fire,
   input  logic                                 dmem_resp_val,
   input  logic [63:0]                          dmem_resp_data,
   input  logic [11:0]                          dmem_resp_tag,
   output logic                                 dpath_wb_val,
   input  logic                                 dpath_wb_rdy,
   output logic [4:0]                           dpath_wb_waddr,
   output logic [63:0]                          dpath_wb_data,
   output logic                                 fpu_fld_val,
   input  logic                                 fpu_fld_rdy,
   output logic [4:0]                           fpu_fld_waddr,
   output logic [63:0]                          fpu_fld_data,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] mem_outstanding,
   output logic                                 mem_idle,
   output logic                                 resp_overflow,
   output logic                                 ack_underflow
);

   localparam int AW = $clog2(RESP_DEPTH);
   localparam int CW = $clog2(MAX_OUTSTANDING+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic        resp_xf;
   logic [2:0]  resp_type;
   logic [2:0]  resp_alo;
   logic [4:0]  resp_waddr;

   assign {resp_xf, resp_type, resp_alo, resp_waddr} = dmem_resp_tag;

   logic [7:0]  sel_b;
   logic [15:0] sel_h;
   logic [31:0] sel_w;
   logic        uns;
   logic [63:0] fmt_data;

   // type[2] marks the unsigned variants; FP loads never sign-extend
   always_comb begin
      sel_b = dmem_resp_data[{resp_alo, 3'b000} +: 8];
      sel_h = dmem_resp_data[{resp_alo[2:1], 4'b0000} +: 16];
      sel_w = dmem_resp_data[{resp_alo[2], 5'b00000} +: 32];
      uns   = resp_type[2] | resp_xf;
      case (resp_type[1:0])
         2'd0:    fmt_data = uns ? {56'd0, sel_b} : {{56{sel_b[7]}}, sel_b};
         2'd1:    fmt_data = uns ? {48'd0, sel_h} : {{48{sel_h[15]}}, sel_h};
         2'd2:    fmt_data = uns ? {32'd0, sel_w} : {{32{sel_w[31]}}, sel_w};
         default: fmt_data = dmem_resp_data;
      endcase
   end

   logic [69:0] fifo_mem [RESP_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        head_xf;
   logic [4:0]  head_waddr;
   logic [63:0] head_data;
   logic        enq_req;
   logic        enq;
   logic        deq;
   logic        bypass;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign {head_xf, head_waddr, head_data} = fifo_mem[rd_ptr[AW-1:0]];

   // integer responses to x0 are store/flush acks: count only, never queued
   assign enq_req = dmem_resp_val & (resp_xf | (resp_waddr != 5'd0));
   assign deq     = ~empty & (head_xf ? fpu_fld_rdy : dpath_wb_rdy);

`ifdef RESP_BYPASS_EN
   assign bypass = enq_req & empty & (resp_xf ? fpu_fld_rdy : dpath_wb_rdy);
`else
   assign bypass = 1'b0;
`endif

   assign enq = enq_req & ~bypass & (~full | deq);

   always_ff @(posedge clk) begin
      if (enq) fifo_mem[wr_ptr[AW-1:0]] <= {resp_xf, resp_waddr, fmt_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         resp_overflow <= 1'b0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (deq) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (enq_req & ~bypass & full & ~deq) resp_overflow <= 1'b1;
      end
   end

   logic        out_val;
   logic        out_xf;
   logic [4:0]  out_waddr;
   logic [63:0] out_data;

   // waddr/data are forced to zero whenever the matching val is low
   always_comb begin
      out_val   = ~empty;
      out_xf    = head_xf;
      out_waddr = head_waddr;
      out_data  = head_data;
`ifdef RESP_BYPASS_EN
      if (bypass) begin
         out_val   = 1'b1;
         out_xf    = resp_xf;
         out_waddr = resp_waddr;
         out_data  = fmt_data;
      end
`endif
      dpath_wb_val   = out_val & ~out_xf;
      fpu_fld_val    = out_val & out_xf;
      dpath_wb_waddr = dpath_wb_val ? out_waddr : 5'd0;
      dpath_wb_data  = dpath_wb_val ? out_data  : 64'd0;
      fpu_fld_waddr  = fpu_fld_val  ? out_waddr : 5'd0;
      fpu_fld_data   = fpu_fld_val  ? out_data  : 64'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_outstanding <= '0;
         ack_underflow   <= 1'b0;
      end else if (dmem_req_fire & ~dmem_resp_val) begin
         if (mem_outstanding != CNT_MAX) mem_outstanding <= mem_outstanding + CW'(1);
      end else if (~dmem_req_fire & dmem_resp_val) begin
         if (mem_outstanding == '0) ack_underflow <= 1'b1;
         else mem_outstanding <= mem_outstanding - CW'(1);
      end
   end

   assign mem_idle = (mem_outstanding == '0) & empty;

endmodule

// File: tb/tb_riscv_dmem_resp_unit.sv
// Self-checking bench for riscv_dmem_resp_unit: format table, directed corner sequences, random vs queue model.
module tb_riscv_dmem_resp_unit;

   localparam int DEPTH = 4;
   localparam int MAXO  = 8;
   localparam int CW    = $clog2(MAXO+1);
   localparam logic [2:0] MT_B = 3'd0, MT_H = 3'd1, MT_W = 3'd2, MT_D = 3'd3,
                          MT_BU = 3'd4, MT_HU = 3'd5, MT_WU = 3'd6;

   logic          clk = 1'b0;
   logic          reset;
   logic          dmem_req_fire;
   logic          dmem_resp_val;
   logic [63:0]   dmem_resp_data;
   logic [11:0]   dmem_resp_tag;
   logic          dpath_wb_val;
   logic          dpath_wb_rdy;
   logic [4:0]    dpath_wb_waddr;
   logic [63:0]   dpath_wb_data;
   logic          fpu_fld_val;
   logic          fpu_fld_rdy;
   logic [4:0]    fpu_fld_waddr;
   logic [63:0]   fpu_fld_data;
   logic [CW-1:0] mem_outstanding;
   logic          mem_idle;
   logic          resp_overflow;
   logic          ack_underflow;

   riscv_dmem_resp_unit #(.RESP_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset), .dmem_req_fire(dmem_req_fire), .dmem_resp_val(dmem_resp_val),
      .dmem_resp_data(dmem_resp_data), .dmem_resp_tag(dmem_resp_tag),
      .dpath_wb_val(dpath_wb_val), .dpath_wb_rdy(dpath_wb_rdy), .dpath_wb_waddr(dpath_wb_waddr),
      .dpath_wb_data(dpath_wb_data), .fpu_fld_val(fpu_fld_val), .fpu_fld_rdy(fpu_fld_rdy),
      .fpu_fld_waddr(fpu_fld_waddr), .fpu_fld_data(fpu_fld_data), .mem_outstanding(mem_outstanding),
      .mem_idle(mem_idle), .resp_overflow(resp_overflow), .ack_underflow(ack_underflow));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input bit fire, input bit rv, input logic xf, input logic [2:0] typ,
                        input logic [2:0] alo, input logic [4:0] wa, input logic [63:0] d);
      dmem_req_fire  = fire;
      dmem_resp_val  = rv;
      dmem_resp_tag  = {xf, typ, alo, wa};
      dmem_resp_data = d;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, MT_D, 0, 0, 64'd0);
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // reference formatting: pick the naturally aligned field containing addr_lo, then extend
   function automatic logic [63:0] ref_fmt(input logic xf, input logic [2:0] typ,
                                           input logic [2:0] alo, input logic [63:0] d);
      logic [63:0] v;
      logic [63:0] mask;
      int sz;
      bit sgn;
      case (typ)
         MT_B, MT_BU: sz = 1;
         MT_H, MT_HU: sz = 2;
         MT_W, MT_WU: sz = 4;
         default:     sz = 8;
      endcase
      if (sz == 8) return d;
      sgn  = !xf && (typ == MT_B || typ == MT_H || typ == MT_W);
      mask = (64'd1 << (8*sz)) - 64'd1;
      v    = (d >> (8 * (int'(alo) - (int'(alo) % sz)))) & mask;
      if (sgn && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   typedef struct {
      logic        xf;
      logic [2:0]  typ;
      logic [2:0]  alo;
      logic [4:0]  wa;
      logic [63:0] d;
      logic [63:0] exp;
   } vec_t;

   typedef struct packed {
      logic        xf;
      logic [4:0]  wa;
      logic [63:0] d;
   } ent_t;

   vec_t vecs[12];
   ent_t q[$];
   int   cnt;
   bit   ovf, unf;

   initial begin
      vecs[0]  = '{0, MT_B,  3, 5,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
      vecs[1]  = '{0, MT_BU, 3, 5,  64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080};
      vecs[2]  = '{1, MT_W,  4, 2,  64'hBF80_0000_0000_0000, 64'h0000_0000_BF80_0000};
      vecs[3]  = '{0, MT_H,  6, 9,  64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_8123};
      vecs[4]  = '{0, MT_HU, 2, 10, 64'h8123_4567_89AB_CDEF, 64'h0000_0000_0000_89AB};
      vecs[5]  = '{0, MT_W,  0, 11, 64'h8123_4567_89AB_CDEF, 64'hFFFF_FFFF_89AB_CDEF};
      vecs[6]  = '{0, MT_WU, 4, 12, 64'h8123_4567_89AB_CDEF, 64'h0000_0000_8123_4567};
      vecs[7]  = '{0, MT_D,  0, 31, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
      vecs[8]  = '{1, MT_D,  0, 0,  64'hC000_0000_0000_0001, 64'hC000_0000_0000_0001};
      vecs[9]  = '{0, MT_W,  4, 3,  64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF};
      vecs[10] = '{0, MT_B,  7, 4,  64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F};
      vecs[11] = '{1, MT_W,  0, 1,  64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};

      dpath_wb_rdy = 1'b1;
      fpu_fld_rdy  = 1'b1;
      step();
      do_reset();

      chk("rst_wb_val", dpath_wb_val, 0);
      chk("rst_fld_val", fpu_fld_val, 0);
      chk("rst_outstanding", mem_outstanding, 0);
      chk("rst_idle", mem_idle, 1);
      chk("rst_flags", {resp_overflow, ack_underflow}, 0);
      chk("rst_data", dpath_wb_data | fpu_fld_data, 0);

      // format table
      foreach (vecs[i]) begin
         drive(1, 0, 0, MT_D, 0, 0, 0);
         step();
         drive(0, 1, vecs[i].xf, vecs[i].typ, vecs[i].alo, vecs[i].wa, vecs[i].d);
         step();
         idle_in();
         chk($sformatf("vec%0d_wb_val", i), dpath_wb_val, !vecs[i].xf);
         chk($sformatf("vec%0d_fld_val", i), fpu_fld_val, vecs[i].xf);
         chk($sformatf("vec%0d_waddr", i), vecs[i].xf ? fpu_fld_waddr : dpath_wb_waddr, vecs[i].wa);
         chk($sformatf("vec%0d_data", i), vecs[i].xf ? fpu_fld_data : dpath_wb_data, vecs[i].exp);
         step();
         chk($sformatf("vec%0d_idle", i), mem_idle, 1);
      end

      // counter: three fires then a store ack, then fire+ack together
      for (int k = 0; k < 3; k++) begin drive(1, 0, 0, MT_D, 0, 0, 0); step(); end
      chk("cnt_three", mem_outstanding, 3);
      drive(0, 1, 0, MT_D, 0, 0, 64'h1234);
      step();
      idle_in();
      chk("cnt_ack", mem_outstanding, 2);
      chk("ack_not_queued", dpath_wb_val, 0);
      chk("ack_not_idle", mem_idle, 0);
      drive(1, 1, 0, MT_D, 0, 0, 0);
      step();
      chk("cnt_fire_ack", mem_outstanding, 2);
      drive(0, 1, 0, MT_D, 0, 0, 0); step();
      drive(0, 1, 0, MT_D, 0, 0, 0); step();
      idle_in();
      chk("cnt_drained", mem_outstanding, 0);
      chk("no_underflow", ack_underflow, 0);
      drive(0, 1, 0, MT_D, 0, 0, 0); step();
      idle_in();
      chk("underflow_cnt", mem_outstanding, 0);
      chk("underflow_flag", ack_underflow, 1);
      do_reset();

      // FP load held behind a stalled integer head
      dpath_wb_rdy = 1'b0;
      drive(1, 0, 0, MT_D, 0, 0, 0); step();
      drive(1, 0, 0, MT_D, 0, 0, 0); step();
      drive(0, 1, 0, MT_D, 0, 1, 64'hAAAA_0000_0000_0001); step();
      drive(0, 1, 1, MT_D, 0, 7, 64'hBBBB_0000_0000_0007); step();
      idle_in();
      chk("stall_wb_val", dpath_wb_val, 1);
      chk("stall_wb_waddr", dpath_wb_waddr, 1);
      chk("stall_fld_blocked", fpu_fld_val, 0);
      step();
      chk("stall_stable_data", dpath_wb_data, 64'hAAAA_0000_0000_0001);
      chk("stall_stable_fld", fpu_fld_val, 0);
      dpath_wb_rdy = 1'b1;
      step();
      chk("stall_fld_val", fpu_fld_val, 1);
      chk("stall_fld_waddr", fpu_fld_waddr, 7);
      chk("stall_fld_data", fpu_fld_data, 64'hBBBB_0000_0000_0007);
      chk("stall_wb_done", dpath_wb_val, 0);
      step();
      chk("stall_idle", mem_idle, 1);

      // overflow: five responses into four entries while stalled
      dpath_wb_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin drive(1, 0, 0, MT_D, 0, 0, 0); step(); end
      for (int k = 1; k <= 5; k++) begin drive(0, 1, 0, MT_D, 0, 5'(k), 64'(k)); step(); end
      idle_in();
      chk("ovf_flag", resp_overflow, 1);
      chk("ovf_cnt", mem_outstanding, 0);
      dpath_wb_rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf_drain%0d", k), {dpath_wb_val, dpath_wb_waddr}, {1'b1, 5'(k)});
         step();
      end
      chk("ovf_empty", dpath_wb_val, 0);
      do_reset();

      // full FIFO with same-cycle dequeue accepts the fifth response
      dpath_wb_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin drive(1, 0, 0, MT_D, 0, 0, 0); step(); end
      for (int k = 1; k <= 4; k++) begin drive(0, 1, 0, MT_D, 0, 5'(k), 64'(k)); step(); end
      dpath_wb_rdy = 1'b1;
      drive(0, 1, 0, MT_D, 0, 5, 64'd5);
      step();
      idle_in();
      chk("fulldeq_no_ovf", resp_overflow, 0);
      for (int k = 2; k <= 5; k++) begin
         chk($sformatf("fulldeq_drain%0d", k), {dpath_wb_val, dpath_wb_waddr}, {1'b1, 5'(k)});
         step();
      end
      chk("fulldeq_empty", mem_idle, 1);

      // reset with queued entries and outstanding requests
      dpath_wb_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin drive(1, 0, 0, MT_D, 0, 0, 0); step(); end
      drive(0, 1, 0, MT_D, 0, 3, 64'd3); step();
      drive(0, 1, 1, MT_D, 0, 4, 64'd4); step();
      idle_in();
      chk("prerst_cnt", mem_outstanding, 3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_vals", {dpath_wb_val, fpu_fld_val}, 0);
      chk("midrst_cnt", mem_outstanding, 0);
      chk("midrst_idle", mem_idle, 1);
      chk("midrst_flags", {resp_overflow, ack_underflow}, 0);
      dpath_wb_rdy = 1'b1;
      step();
      chk("midrst_still_empty", mem_idle, 1);

      // random traffic against the queue model
      q.delete();
      cnt = 0; ovf = 0; unf = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit          fire, rv, wr, fr, dq, en, full_before;
         logic        xf;
         logic [2:0]  typ, alo;
         logic [4:0]  wa;
         logic [63:0] d;
         bit          ewv, efv;
         logic [4:0]  ewa, efa;
         logic [63:0] ewd, efd;

         ewv = 0; efv = 0; ewa = 0; efa = 0; ewd = 0; efd = 0;
         if (q.size() > 0) begin
            if (q[0].xf) begin efv = 1; efa = q[0].wa; efd = q[0].d; end
            else         begin ewv = 1; ewa = q[0].wa; ewd = q[0].d; end
         end
         chk("rnd_wb_val", dpath_wb_val, ewv);
         chk("rnd_wb_waddr", dpath_wb_waddr, ewa);
         chk("rnd_wb_data", dpath_wb_data, ewd);
         chk("rnd_fld_val", fpu_fld_val, efv);
         chk("rnd_fld_waddr", fpu_fld_waddr, efa);
         chk("rnd_fld_data", fpu_fld_data, efd);
         chk("rnd_outstanding", mem_outstanding, cnt);
         chk("rnd_idle", mem_idle, (cnt == 0 && q.size() == 0));
         chk("rnd_flags", {resp_overflow, ack_underflow}, {ovf, unf});

         fire = ($urandom_range(0, 1) == 0);
         rv   = (cnt > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
         if (cnt == 0 && fire) rv = 0;
         xf   = ($urandom_range(0, 3) == 0);
         typ  = xf ? (($urandom_range(0, 1) == 0) ? MT_W : MT_D) : 3'($urandom_range(0, 6));
         alo  = 3'($urandom_range(0, 7));
         wa   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         d    = {$urandom, $urandom};
         wr   = ($urandom_range(0, 3) != 0);
         fr   = ($urandom_range(0, 3) != 0);
         drive(fire, rv, xf, typ, alo, wa, d);
         dpath_wb_rdy = wr;
         fpu_fld_rdy  = fr;

         dq = (q.size() > 0) && (q[0].xf ? fr : wr);
         en = rv && (xf || wa != 0);
         full_before = (q.size() == DEPTH);
         if (dq) void'(q.pop_front());
         if (en) begin
            if (full_before && !dq) ovf = 1;
            else q.push_back('{xf, wa, ref_fmt(xf, typ, alo, d)});
         end
         if (fire && !rv) begin
            if (cnt < MAXO) cnt++;
         end else if (!fire && rv) begin
            if (cnt == 0) unf = 1;
            else cnt--;
         end
         step();
      end
      idle_in();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
